mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates a fetch port and a load/store port onto one shared memory
//   port, with at most one transaction outstanding. Data normally wins;
//   a pending fetch wins once STARVE_MAX consecutive data grants have been
//   issued while it waited.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr                 fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata      fetch grant, response pulse, data
//   d_req/d_we/d_addr/d_wdata/d_size  load/store request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata         data grant, response pulse, load data
//   mem_req/we/addr/wdata/size     shared-port request bundle
//   mem_gnt/mem_rvalid/mem_rdata   shared-port handshake and response
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_size,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_size,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e      state_q, state_d;
  logic        owner_d_q, owner_d_d;   // 1 = data port owns the transaction
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic [3:0]  starve_q, starve_d;
  logic        pick_fetch;

  always_comb begin
    state_d   = state_q;
    owner_d_d = owner_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    starve_d  = starve_q;

    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = '0;

    pick_fetch = if_req && (!d_req || (starve_q >= STARVE_LIM));

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d = REQ;
          if (pick_fetch) begin
            owner_d_d = 1'b0;
            we_d      = 1'b0;
            addr_d    = if_addr;
            wdata_d   = '0;
            size_d    = 3'b010;
          end else begin
            owner_d_d = 1'b1;
            we_d      = d_we;
            addr_d    = d_addr;
            wdata_d   = d_wdata;
            size_d    = d_size;
          end
        end
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_size  = size_q;
        if (mem_gnt) begin
          state_d = RESP;
          if (owner_d_q) begin
            d_gnt = 1'b1;
            // Only data grants that actually make a fetch wait count.
            if (if_req && (starve_q != 4'hF)) starve_d = starve_q + 4'd1;
          end else begin
            if_gnt   = 1'b1;
            starve_d = '0;
          end
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (owner_d_q) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end else begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset is synchronous, so the state may still read REQ/RESP during the
    // reset cycle; outputs are forced quiet so no pulse escapes an abort.
    if (rst) begin
      if_gnt    = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      d_gnt     = 1'b0;
      d_rvalid  = 1'b0;
      d_rdata   = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_size  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_d_q <= owner_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      starve_q  <= starve_d;
    end
  end

endmodule
